// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle between a requester and the bit-serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  modport master (output start, a, b, input busy, done, sum, carry);
  modport slave  (input start, a, b, output busy, done, sum, carry);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with one full-adder cell, a carry flop and a parallel registered result
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_res;
  always_comb begin
    w_s   = r_a[0] ^ r_b[0] ^ r_c;
    w_c   = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    w_res = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_c   <= w_c;
      r_res <= w_res;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_sum   <= w_res;
        r_carry <= w_c;
        r_state <= DONE;
      end
    end else if (bus.start) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_state <= RUN;
    end else begin
      r_state <= IDLE;
    end
  end
  assign bus.busy  = r_state == RUN;
  assign bus.done  = r_state == DONE;
  assign bus.sum   = r_sum;
  assign bus.carry = r_carry;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed plus randomized checks of serial_adder against an arithmetic reference
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_adder_if #(.WIDTH(8)) bus ();
  serial_adder_if #(.WIDTH(1)) bus1 ();
  serial_adder #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  int errors = 0;
  int checks = 0;
  logic [8:0] exp_res;
  logic [7:0] prev_sum;
  logic       prev_carry;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    exp_res   = {1'b0, a} + {1'b0, b};
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic finish8(input bit junk);
    for (int i = 0; i < 8; i++) begin
      check("busy_run", 32'(bus.busy), 1);
      check("done_run", 32'(bus.done), 0);
      check("sum_hold", 32'(bus.sum), 32'(prev_sum));
      check("carry_hold", 32'(bus.carry), 32'(prev_carry));
      if (junk) begin
        bus.start = 1'($urandom);
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_pulse", 32'(bus.done), 1);
    check("busy_done", 32'(bus.busy), 0);
    check("sum", 32'(bus.sum), 32'(exp_res[7:0]));
    check("carry", 32'(bus.carry), 32'(exp_res[8]));
    prev_sum   = exp_res[7:0];
    prev_carry = exp_res[8];
  endtask
  initial begin
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus1.start = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    prev_sum   = 8'h00;
    prev_carry = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_sum", 32'(bus.sum), 0);
    check("rst_carry", 32'(bus.carry), 0);
    check("rst_done1", 32'(bus1.done), 0);
    launch8(8'h00, 8'h00);
    finish8(1'b0);
    @(negedge clk);
    check("idle_done", 32'(bus.done), 0);
    check("idle_busy", 32'(bus.busy), 0);
    launch8(8'hFF, 8'h01);
    finish8(1'b0);
    @(negedge clk);
    launch8(8'hA5, 8'h5A);
    bus.start = 1'b1;
    bus.a     = 8'h11;
    bus.b     = 8'h22;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("ignored_busy", 32'(bus.busy), 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("ignored_busy_end", 32'(bus.busy), 1);
    @(posedge clk);
    @(negedge clk);
    check("ignored_done", 32'(bus.done), 1);
    check("ignored_sum", 32'(bus.sum), 32'h0FF);
    check("ignored_carry", 32'(bus.carry), 0);
    prev_sum   = 8'hFF;
    prev_carry = 1'b0;
    @(negedge clk);
    launch8(8'h80, 8'h80);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_sum", 32'(bus.sum), 0);
    check("abort_carry", 32'(bus.carry), 0);
    prev_sum   = 8'h00;
    prev_carry = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("abort_no_done", 32'(bus.done), 0);
      @(negedge clk);
    end
    launch8(8'h0F, 8'h01);
    finish8(1'b0);
    @(negedge clk);
    launch8(8'h03, 8'h04);
    finish8(1'b0);
    launch8(8'h7F, 8'h7F);
    finish8(1'b0);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      launch8(8'($urandom), 8'($urandom));
      finish8(1'b1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
    for (int v = 0; v < 4; v++) begin
      logic [1:0] p;
      logic [1:0] r;
      p = 2'(v);
      r = {1'b0, p[1]} + {1'b0, p[0]};
      bus1.start = 1'b1;
      bus1.a     = p[1];
      bus1.b     = p[0];
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      check("w1_busy", 32'(bus1.busy), 1);
      check("w1_early_done", 32'(bus1.done), 0);
      @(posedge clk);
      @(negedge clk);
      check("w1_done", 32'(bus1.done), 1);
      check("w1_sum", 32'(bus1.sum), 32'(r[0]));
      check("w1_carry", 32'(bus1.carry), 32'(r[1]));
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
